// File: rtl/wiegand26_tx_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module : wiegand26_tx_if
// Bus between the register block (master) and the Wiegand-26 transmitter (slave)
// Rev    : 1.0
// -----------------------------------------------------------------------------
interface wiegand26_tx_if;
  logic        en;
  logic [25:0] data;
  logic [1:0]  wigend;
  // Active-low completion pulse; named int_n because "int" is a reserved word.
  logic        int_n;
  logic        busy;

  modport master (
    output en,
    output data,
    input  wigend,
    input  int_n,
    input  busy
  );

  modport slave (
    input  en,
    input  data,
    output wigend,
    output int_n,
    output busy
  );
endinterface

`default_nettype wire

// File: rtl/wiegand26_tx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module : wiegand26_tx
// Serialises a 26-bit word MSB-first onto the Wiegand D0/D1 lines, then pulses int_n.
// Rev    : 1.0
// -----------------------------------------------------------------------------
module wiegand26_tx #(
  parameter int PULSE_CYC   = 2700,
  parameter int GAP_CYC     = 27000,
  parameter int INT_CYC     = 4,
  parameter int AUTO_PARITY = 0
) (
  input  logic          clk,
  input  logic          rst,
  wiegand26_tx_if.slave bus
);

  localparam int CYC_PG  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int CYC_MAX = (CYC_PG > INT_CYC) ? CYC_PG : INT_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX) + 1;

  localparam logic [CYC_W-1:0] c_cyc_zero   = '0;
  localparam logic [CYC_W-1:0] c_cyc_one    = CYC_W'(1);
  localparam logic [CYC_W-1:0] c_pulse_last = CYC_W'(PULSE_CYC - 1);
  localparam logic [CYC_W-1:0] c_gap_last   = CYC_W'(GAP_CYC - 1);
  localparam logic [CYC_W-1:0] c_int_last   = CYC_W'(INT_CYC - 1);
  localparam logic [4:0]       c_last_bit   = 5'd25;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q,   state_d;
  logic [CYC_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [25:0]      shift_q,   shift_d;
  logic [1:0]       wigend_q,  wigend_d;
  logic             int_n_q,   int_n_d;
  logic             busy_q,    busy_d;

  logic [25:0]      w_frame;

  generate
    if (AUTO_PARITY != 0) begin : g_parity
      // Even parity over the upper half in bit 25, odd parity over the lower half in bit 0.
      assign w_frame = {^bus.data[24:13], bus.data[24:1], ~^bus.data[12:1]};
    end else begin : g_verbatim
      assign w_frame = bus.data;
    end
  endgenerate

  // A '1' bit pulls D1 (wigend[1]) low, a '0' bit pulls D0 (wigend[0]) low.
  function automatic logic [1:0] line_for(input logic bit_val);
    return bit_val ? 2'b01 : 2'b10;
  endfunction

  always_comb begin
    state_d   = state_q;
    cyc_cnt_d = cyc_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    wigend_d  = wigend_q;
    int_n_d   = int_n_q;
    busy_d    = busy_q;

    unique case (state_q)
      IDLE: begin
        wigend_d = 2'b11;
        int_n_d  = 1'b1;
        busy_d   = 1'b0;
        if (bus.en) begin
          state_d   = PULSE;
          shift_d   = w_frame;
          bit_cnt_d = 5'd0;
          cyc_cnt_d = c_cyc_zero;
          busy_d    = 1'b1;
          wigend_d  = line_for(w_frame[25]);
        end
      end

      PULSE: begin
        if (cyc_cnt_q == c_pulse_last) begin
          state_d   = GAP;
          cyc_cnt_d = c_cyc_zero;
          wigend_d  = 2'b11;
        end else begin
          cyc_cnt_d = cyc_cnt_q + c_cyc_one;
        end
      end

      GAP: begin
        if (cyc_cnt_q == c_gap_last) begin
          cyc_cnt_d = c_cyc_zero;
          if (bit_cnt_q == c_last_bit) begin
            state_d = DONE;
            int_n_d = 1'b0;
          end else begin
            // The next bit to send is shift_q[24]; it becomes the MSB on this edge.
            state_d   = PULSE;
            shift_d   = {shift_q[24:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 5'd1;
            wigend_d  = line_for(shift_q[24]);
          end
        end else begin
          cyc_cnt_d = cyc_cnt_q + c_cyc_one;
        end
      end

      DONE: begin
        if (cyc_cnt_q == c_int_last) begin
          state_d   = IDLE;
          cyc_cnt_d = c_cyc_zero;
          int_n_d   = 1'b1;
          busy_d    = 1'b0;
        end else begin
          cyc_cnt_d = cyc_cnt_q + c_cyc_one;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cyc_cnt_q <= c_cyc_zero;
      bit_cnt_q <= 5'd0;
      shift_q   <= 26'd0;
      wigend_q  <= 2'b11;
      int_n_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      wigend_q  <= wigend_d;
      int_n_q   <= int_n_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.wigend = wigend_q;
  assign bus.int_n  = int_n_q;
  assign bus.busy   = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_wiegand26_tx.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module : tb_wiegand26_tx
// Scoreboarded bench: stimulus queues expected words, a line decoder pops and compares.
// Rev    : 1.0
// -----------------------------------------------------------------------------
module tb_wiegand26_tx;

  localparam int PULSE_CYC = 4;
  localparam int GAP_CYC   = 8;
  localparam int INT_CYC   = 2;
  localparam int FRAME_CYC = 26 * (PULSE_CYC + GAP_CYC);

  logic clk = 1'b0;
  logic rst;
  logic sel = 1'b0;

  int checks      = 0;
  int errors      = 0;
  int frames_done = 0;

  logic [25:0] exp_q[$];

  wiegand26_tx_if bus0();
  wiegand26_tx_if bus_p();

  wiegand26_tx #(
    .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC), .INT_CYC(INT_CYC), .AUTO_PARITY(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  wiegand26_tx #(
    .PULSE_CYC(PULSE_CYC), .GAP_CYC(GAP_CYC), .INT_CYC(INT_CYC), .AUTO_PARITY(1)
  ) dut_p (
    .clk(clk), .rst(rst), .bus(bus_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Word that should appear on the lines, derived by counting ones.
  function automatic logic [25:0] model_word(input logic [25:0] d, input logic par);
    logic [25:0] r;
    int ones_hi;
    int ones_lo;
    r = d;
    if (par) begin
      ones_hi = 0;
      ones_lo = 0;
      for (int k = 13; k <= 24; k++) ones_hi += int'(d[k]);
      for (int k = 1; k <= 12; k++)  ones_lo += int'(d[k]);
      r[25] = ((ones_hi % 2) == 1);
      r[0]  = ((ones_lo % 2) == 0);
    end
    return r;
  endfunction

  // ---------------- monitor: decodes the lines of the selected DUT ----------------
  logic [1:0]  prev_w   = 2'b11;
  logic        prev_int = 1'b1;
  logic        in_frame = 1'b0;
  logic [1:0]  cur_line = 2'b11;
  logic [25:0] word     = '0;
  int nbits = 0, low_len = 0, high_len = 0, int_len = 0, cyc = 0, start_cyc = 0;

  always @(negedge clk) begin : monitor
    logic [1:0]  w;
    logic        i_n;
    logic        b;
    logic [25:0] e;
    w   = sel ? bus_p.wigend : bus0.wigend;
    i_n = sel ? bus_p.int_n  : bus0.int_n;
    b   = sel ? bus_p.busy   : bus0.busy;
    cyc++;
    if (rst) begin
      chk("reset_wigend", 32'(w), 32'h3);
      chk("reset_int", 32'(i_n), 32'h1);
      chk("reset_busy", 32'(b), 32'h0);
      in_frame = 1'b0;
      nbits    = 0;
      word     = '0;
      prev_w   = 2'b11;
      prev_int = 1'b1;
    end else begin
      chk("wigend_not_00", 32'(w != 2'b00), 32'h1);
      if (!i_n) chk("int_while_line_low", 32'(w), 32'h3);

      if (w != 2'b11) begin
        if (prev_w == 2'b11) begin
          if (nbits == 0) begin
            start_cyc = cyc;
            in_frame  = 1'b1;
            chk("frame_expected", 32'(exp_q.size() != 0), 32'h1);
          end else begin
            chk("gap_len", 32'(high_len), 32'(GAP_CYC));
          end
          chk("bit_count_le_25", 32'(nbits <= 25), 32'h1);
          cur_line = w;
          low_len  = 1;
        end else begin
          low_len++;
          chk("pulse_line_stable", 32'(w), 32'(cur_line));
        end
      end else if (prev_w != 2'b11) begin
        chk("pulse_len", 32'(low_len), 32'(PULSE_CYC));
        word     = {word[24:0], (cur_line == 2'b01)};
        nbits++;
        high_len = 1;
      end else begin
        high_len++;
      end

      if (!i_n && prev_int) begin
        chk("bits_before_int", 32'(nbits), 32'd26);
        chk("int_fall_delay", 32'(cyc - start_cyc), 32'(FRAME_CYC));
        chk("frame_expected_at_int", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame_word", 32'(word), 32'(e));
        end
        int_len = 1;
      end else if (!i_n) begin
        int_len++;
      end else if (!prev_int) begin
        chk("int_len", 32'(int_len), 32'(INT_CYC));
        in_frame = 1'b0;
        nbits    = 0;
        word     = '0;
        frames_done++;
      end

      chk("busy", 32'(b), 32'(in_frame));
      prev_w   = w;
      prev_int = i_n;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic which, input logic [25:0] d, input int hold);
    @(negedge clk);
    sel = which;
    if (which) begin
      bus_p.data = d;
      bus_p.en   = 1'b1;
    end else begin
      bus0.data = d;
      bus0.en   = 1'b1;
    end
    exp_q.push_back(model_word(d, which));
    repeat (hold) @(negedge clk);
    bus0.en  = 1'b0;
    bus_p.en = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string name);
    int n;
    n = 0;
    while (frames_done < target && n < 2 * FRAME_CYC) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(frames_done >= target), 32'h1);
  endtask

  initial begin : stim
    int          target;
    logic [25:0] d;
    logic [25:0] m;
    bus0.en  = 1'b0;
    bus0.data = '0;
    bus_p.en = 1'b0;
    bus_p.data = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("por_wigend", 32'(bus0.wigend), 32'h3);
    chk("por_int", 32'(bus0.int_n), 32'h1);
    chk("por_busy", 32'(bus0.busy), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Idle reset pulse: outputs must respond without a clock edge.
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wigend", 32'(bus0.wigend), 32'h3);
    chk("async_rst_int", 32'(bus0.int_n), 32'h1);
    chk("async_rst_busy", 32'(bus0.busy), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    target = frames_done;

    // Alternating pattern, single-cycle en.
    send(1'b0, 26'h2AAAAAA, 1);
    target++;
    wait_frames(target, "basic_frame_done");

    // en held high; data change mid-frame only affects the restart frame.
    @(negedge clk);
    sel = 1'b0;
    bus0.data = 26'h3FFFFFF;
    bus0.en   = 1'b1;
    exp_q.push_back(model_word(26'h3FFFFFF, 1'b0));
    repeat (5 * (PULSE_CYC + GAP_CYC)) @(negedge clk);
    bus0.data = '0;
    exp_q.push_back(model_word(26'h0, 1'b0));
    target++;
    wait_frames(target, "held_en_frame1_done");
    @(negedge clk);
    bus0.en = 1'b0;
    target++;
    wait_frames(target, "held_en_restart_done");
    repeat (10) @(negedge clk);

    // Reset during the pulse of the 11th bit (bit index 15 of the word).
    d = 26'($urandom);
    m = model_word(d, 1'b0);
    send(1'b0, d, 1);
    repeat (10 * (PULSE_CYC + GAP_CYC)) @(negedge clk);
    #2;
    chk("bit10_line_before_rst", 32'(bus0.wigend), m[15] ? 32'h1 : 32'h2);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midframe_rst_wigend", 32'(bus0.wigend), 32'h3);
    chk("midframe_rst_int", 32'(bus0.int_n), 32'h1);
    chk("midframe_rst_busy", 32'(bus0.busy), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    send(1'b0, 26'($urandom), 1);
    target++;
    wait_frames(target, "post_rst_frame_done");

    // Auto-parity instance: fixed case then random words.
    send(1'b1, 26'h0001FFE, 1);
    target++;
    wait_frames(target, "parity_fixed_done");
    for (int i = 0; i < 3; i++) begin
      send(1'b1, 26'($urandom), 1);
      target++;
      wait_frames(target, "parity_rand_done");
    end

    // Random frames with random en hold lengths.
    for (int i = 0; i < 50; i++) begin
      send(1'b0, 26'($urandom), int'($urandom_range(1, 3)));
      target++;
      wait_frames(target, "rand_frame_done");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
